// File: rtl/prv664_scoreboard_pkg.sv
// prv664_scoreboard_pkg: shared scoreboard types and constants
package prv664_scoreboard_pkg;
  localparam int ITAG_W = 8;
  localparam int SCB_NREG = 32;
  localparam int SCB_CNT_W = 6;
  typedef struct packed {
    logic busy;
    logic [ITAG_W-1:0] itag;
  } scb_entry_t;
endpackage

// File: rtl/scoreboard_update_interface.sv
// scoreboard_update_interface: dispatch-to-scoreboard allocation channel
interface scoreboard_update_interface;
  import prv664_scoreboard_pkg::*;
  logic [4:0] rdindex;
  logic [ITAG_W-1:0] itag;
  logic write;
  modport master(output rdindex, itag, write);
  modport slave(input rdindex, itag, write);
endinterface

// File: rtl/scb_popcnt32.sv
// scb_popcnt32: combinational popcount of the 31 architectural busy bits
module scb_popcnt32
  import prv664_scoreboard_pkg::*;
(
  input  logic [SCB_NREG-2:0]  vec,
  output logic [SCB_CNT_W-1:0] cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < SCB_NREG - 1; i++) cnt += SCB_CNT_W'(vec[i]);
  end
endmodule

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: integer-register busy/itag scoreboard with dispatch allocate,
// dual commit release and wholesale flush
module gpr_scoreboard
  import prv664_scoreboard_pkg::*;
#(
  parameter int ITAG_W  = 8,
  parameter int NCOMMIT = 2
) (
  input  logic                            clk_i,
  input  logic                            arst_i,
  scoreboard_update_interface.slave       scb_update,
  input  logic                            flush_i,
  input  logic [NCOMMIT-1:0]              commit_valid_i,
  input  logic [NCOMMIT-1:0][4:0]         commit_rdindex_i,
  input  logic [NCOMMIT-1:0][ITAG_W-1:0]  commit_itag_i,
  input  logic [4:0]                      rs1_index_i,
  input  logic [4:0]                      rs2_index_i,
  output logic                            rs1_busy_o,
  output logic                            rs2_busy_o,
  output logic [ITAG_W-1:0]               rs1_itag_o,
  output logic [ITAG_W-1:0]               rs2_itag_o,
  output logic [SCB_CNT_W-1:0]            busy_cnt_o
);
  scb_entry_t [SCB_NREG-1:0] ent, nxt;
  logic [SCB_NREG-1:0] rel;
  logic [SCB_NREG-2:0] nbusy;
  logic [SCB_CNT_W-1:0] pcnt;
  always_comb begin
    rel = '0;
    for (int i = 1; i < SCB_NREG; i++)
      for (int k = 0; k < NCOMMIT; k++)
        rel[i] = rel[i] | (commit_valid_i[k] && commit_rdindex_i[k] == 5'(i) &&
                           ent[i].busy && ent[i].itag == commit_itag_i[k]);
  end
  // flush beats allocate beats release; x0 never holds state
  always_comb begin
    nxt = '0;
    for (int i = 1; i < SCB_NREG; i++)
      nxt[i] = flush_i ? '0 :
               (scb_update.write && scb_update.rdindex == 5'(i)) ? {1'b1, scb_update.itag} :
               rel[i] ? '0 : ent[i];
  end
  for (genvar g = 1; g < SCB_NREG; g++) begin : g_busy
    assign nbusy[g-1] = nxt[g].busy;
  end
  scb_popcnt32 u_popcnt (.vec(nbusy), .cnt(pcnt));
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ent        <= '0;
      busy_cnt_o <= '0;
    end else begin
      ent        <= nxt;
      busy_cnt_o <= pcnt;
    end
  end
  assign rs1_busy_o = ent[rs1_index_i].busy;
  assign rs2_busy_o = ent[rs2_index_i].busy;
  assign rs1_itag_o = ent[rs1_index_i].itag;
  assign rs2_itag_o = ent[rs2_index_i].itag;
endmodule

// File: tb/tb_gpr_scoreboard.sv
// tb_gpr_scoreboard: directed scenarios plus random stream against a behavioural model
module tb_gpr_scoreboard;
  logic clk = 0, arst = 1, flush = 0;
  logic [1:0] cv = '0;
  logic [1:0][4:0] crd = '0;
  logic [1:0][7:0] cit = '0;
  logic [4:0] rs1 = '0, rs2 = '0;
  logic b1, b2;
  logic [7:0] t1, t2;
  logic [5:0] cnt;
  int checks = 0, failures = 0;
  bit mbusy[32];
  logic [7:0] mitag[32];

  scoreboard_update_interface upd();

  gpr_scoreboard #(.ITAG_W(8), .NCOMMIT(2)) dut (
    .clk_i(clk), .arst_i(arst), .scb_update(upd), .flush_i(flush),
    .commit_valid_i(cv), .commit_rdindex_i(crd), .commit_itag_i(cit),
    .rs1_index_i(rs1), .rs2_index_i(rs2),
    .rs1_busy_o(b1), .rs2_busy_o(b2), .rs1_itag_o(t1), .rs2_itag_o(t2),
    .busy_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  function automatic int mcount();
    int n = 0;
    for (int i = 1; i < 32; i++) n += int'(mbusy[i]);
    return n;
  endfunction

  task automatic mclear();
    for (int i = 0; i < 32; i++) begin
      mbusy[i] = 0;
      mitag[i] = '0;
    end
  endtask

  // drive one cycle of stimulus, advance the model on the edge, then idle inputs
  task automatic cycle(input logic w, input logic [4:0] rd, input logic [7:0] it, input logic fl,
                       input logic [1:0] v, input logic [4:0] r0, input logic [7:0] q0,
                       input logic [4:0] r1, input logic [7:0] q1);
    bit clr[32];
    logic [4:0] rr[2];
    logic [7:0] qq[2];
    rr[0] = r0; rr[1] = r1; qq[0] = q0; qq[1] = q1;
    upd.write = w; upd.rdindex = rd; upd.itag = it; flush = fl;
    cv = v; crd[0] = r0; cit[0] = q0; crd[1] = r1; cit[1] = q1;
    @(posedge clk);
    if (fl) mclear();
    else begin
      for (int i = 0; i < 32; i++) clr[i] = 0;
      for (int k = 0; k < 2; k++)
        if (v[k] && rr[k] != 0 && mbusy[rr[k]] && mitag[rr[k]] == qq[k]) clr[rr[k]] = 1;
      for (int i = 0; i < 32; i++) if (clr[i]) begin mbusy[i] = 0; mitag[i] = '0; end
      if (w && rd != 0) begin mbusy[rd] = 1; mitag[rd] = it; end
    end
    #1;
    upd.write = 0; upd.rdindex = '0; upd.itag = '0; flush = 0;
    cv = '0; crd = '0; cit = '0;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic [7:0] it);
    cycle(1, rd, it, 0, 2'b00, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    #2;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i); #1;
      checks++;
      if (b1 !== 1'b0 || t1 !== 8'h00 || b2 !== 1'b0 || t2 !== 8'h00) begin
        failures++;
        $display("FAIL reset_lookup idx=%0d got b1=%b t1=%h b2=%b t2=%h expected all 0", i, b1, t1, b2, t2);
      end
    end
    checks++;
    if (cnt !== 6'd0) begin failures++; $display("FAIL reset_cnt got %0d expected 0", cnt); end
    @(negedge clk); arst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midrun();
    for (int i = 1; i <= 5; i++) alloc(5'(i), 8'(8'h50 + i));
    checks++;
    if (cnt !== 6'd5) begin failures++; $display("FAIL midrun_cnt_pre got %0d expected 5", cnt); end
    @(negedge clk); #2; arst = 1; #1;
    rs1 = 5'd3; rs2 = 5'd5; #1;
    checks++;
    if (cnt !== 6'd0) begin failures++; $display("FAIL midrun_cnt got %0d expected 0", cnt); end
    checks++;
    if (b1 !== 1'b0 || t1 !== 8'h00 || b2 !== 1'b0 || t2 !== 8'h00) begin
      failures++;
      $display("FAIL midrun_lookup got b1=%b t1=%h b2=%b t2=%h expected all 0", b1, t1, b2, t2);
    end
    mclear();
    @(negedge clk); arst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_allocate();
    alloc(5'd5, 8'h12);
    rs1 = 5'd5; #1;
    checks++;
    if (b1 !== 1'b1 || t1 !== 8'h12) begin failures++; $display("FAIL alloc_x5 got b=%b t=%h expected 1/12", b1, t1); end
    checks++;
    if (cnt !== 6'd1) begin failures++; $display("FAIL alloc_cnt got %0d expected 1", cnt); end
    alloc(5'd0, 8'h55);
    rs1 = 5'd0; #1;
    checks++;
    if (b1 !== 1'b0 || t1 !== 8'h00 || cnt !== 6'd1) begin
      failures++;
      $display("FAIL alloc_x0 got b=%b t=%h cnt=%0d expected 0/00/1", b1, t1, cnt);
    end
  endtask

  task automatic test_waw();
    alloc(5'd7, 8'h20);
    alloc(5'd7, 8'h21);
    checks++;
    if (cnt !== 6'd2) begin failures++; $display("FAIL waw_cnt got %0d expected 2", cnt); end
    cycle(0, 0, 0, 0, 2'b01, 5'd7, 8'h20, 0, 0);
    rs2 = 5'd7; #1;
    checks++;
    if (b2 !== 1'b1 || t2 !== 8'h21 || cnt !== 6'd2) begin
      failures++;
      $display("FAIL waw_stale got b=%b t=%h cnt=%0d expected 1/21/2", b2, t2, cnt);
    end
    cycle(0, 0, 0, 0, 2'b10, 0, 0, 5'd7, 8'h21);
    checks++;
    if (b2 !== 1'b0 || t2 !== 8'h00 || cnt !== 6'd1) begin
      failures++;
      $display("FAIL waw_release got b=%b t=%h cnt=%0d expected 0/00/1", b2, t2, cnt);
    end
  endtask

  task automatic test_same_cycle();
    alloc(5'd9, 8'h2f);
    cycle(1, 5'd9, 8'h30, 0, 2'b01, 5'd9, 8'h2f, 0, 0);
    rs1 = 5'd9; #1;
    checks++;
    if (b1 !== 1'b1 || t1 !== 8'h30 || cnt !== 6'd2) begin
      failures++;
      $display("FAIL alloc_vs_release got b=%b t=%h cnt=%0d expected 1/30/2", b1, t1, cnt);
    end
    cycle(1, 5'd3, 8'h40, 1, 2'b00, 0, 0, 0, 0);
    rs2 = 5'd3; #1;
    checks++;
    if (b1 !== 1'b0 || b2 !== 1'b0 || t2 !== 8'h00 || cnt !== 6'd0) begin
      failures++;
      $display("FAIL flush_alloc got b9=%b b3=%b t3=%h cnt=%0d expected 0/0/00/0", b1, b2, t2, cnt);
    end
  endtask

  task automatic test_dual_commit();
    alloc(5'd4, 8'h01);
    alloc(5'd6, 8'h02);
    checks++;
    if (cnt !== 6'd2) begin failures++; $display("FAIL dual_cnt_pre got %0d expected 2", cnt); end
    cycle(0, 0, 0, 0, 2'b11, 5'd4, 8'h01, 5'd6, 8'h02);
    rs1 = 5'd4; rs2 = 5'd6; #1;
    checks++;
    if (b1 !== 1'b0 || b2 !== 1'b0 || cnt !== 6'd0) begin
      failures++;
      $display("FAIL dual_both got b4=%b b6=%b cnt=%0d expected 0/0/0", b1, b2, cnt);
    end
    alloc(5'd8, 8'h08);
    alloc(5'd4, 8'h01);
    cycle(0, 0, 0, 0, 2'b11, 5'd4, 8'h01, 5'd4, 8'h05);
    checks++;
    if (b1 !== 1'b0 || t1 !== 8'h00 || cnt !== 6'd1) begin
      failures++;
      $display("FAIL dual_same_rd got b=%b t=%h cnt=%0d expected 0/00/1", b1, t1, cnt);
    end
    alloc(5'd4, 8'h01);
    cycle(0, 0, 0, 0, 2'b11, 5'd4, 8'h01, 5'd4, 8'h01);
    checks++;
    if (b1 !== 1'b0 || cnt !== 6'd1) begin
      failures++;
      $display("FAIL dual_dup got b=%b cnt=%0d expected 0/1", b1, cnt);
    end
  endtask

  task automatic test_random();
    logic w, fl;
    logic [1:0] v;
    logic [4:0] rd, r[2];
    logic [7:0] it, q[2];
    for (int n = 0; n < 10000; n++) begin
      w = 1'($urandom_range(0, 1));
      rd = 5'($urandom_range(0, 31));
      it = 8'($urandom_range(0, 15));
      fl = ($urandom_range(0, 99) == 0);
      v = 2'($urandom_range(0, 3));
      for (int k = 0; k < 2; k++) begin
        r[k] = 5'($urandom_range(0, 31));
        q[k] = ($urandom_range(0, 3) != 0 && mbusy[r[k]]) ? mitag[r[k]] : 8'($urandom_range(0, 15));
      end
      cycle(w, rd, it, fl, v, r[0], q[0], r[1], q[1]);
      rs1 = 5'($urandom_range(0, 31)); rs2 = 5'($urandom_range(0, 31)); #1;
      checks++;
      if (b1 !== mbusy[rs1] || t1 !== mitag[rs1]) begin
        failures++;
        $display("FAIL rand_rs1 cyc=%0d idx=%0d got %b/%h expected %b/%h", n, rs1, b1, t1, mbusy[rs1], mitag[rs1]);
      end
      checks++;
      if (b2 !== mbusy[rs2] || t2 !== mitag[rs2]) begin
        failures++;
        $display("FAIL rand_rs2 cyc=%0d idx=%0d got %b/%h expected %b/%h", n, rs2, b2, t2, mbusy[rs2], mitag[rs2]);
      end
      checks++;
      if (int'(cnt) != mcount()) begin
        failures++;
        $display("FAIL rand_cnt cyc=%0d got %0d expected %0d", n, cnt, mcount());
      end
    end
  endtask

  initial begin
    upd.write = 0; upd.rdindex = '0; upd.itag = '0;
    mclear();
    test_reset();
    test_reset_midrun();
    test_allocate();
    test_waw();
    test_same_cycle();
    test_dual_commit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
